// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//   N-client write arbiter in front of the frame buffer write port (port A).
//   Each drawing engine presents one write at a time with cl_req held high.
//   A single owner is granted and streams one write per cycle until it marks
//   cl_last, drops cl_req, or (round-robin mode only) uses up BURST_MAX writes.
//   Writes that fall outside the frame buffer are acknowledged but dropped,
//   and the first offending client is captured in a sticky error register.
//
// Ports
//   clk, rst_n       100 MHz clock, asynchronous active-low reset
//   cl_req[i]        client i has a write presented
//   cl_addr/cl_data  per-client address/pixel, client i at [i*W +: W]
//   cl_last[i]       presented write is the final write of the burst
//   cl_gnt[i]        registered one-hot grant
//   cl_ack[i]        presented write consumed this cycle (gnt & req)
//   fb_we/addr/data  registered frame buffer write port
//   busy             a grant is held
//   err_clr          synchronous clear of err_oob/err_client
//   err_oob          sticky out-of-bounds flag
//   err_client       first client that wrote out of bounds since last clear
module fb_write_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 24,
    parameter int FB_DEPTH    = 76800,
    parameter int RR_MODE     = 0,
    parameter int BURST_MAX   = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLIENTS-1:0]        cl_req,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cl_data,
    input  logic [NUM_CLIENTS-1:0]        cl_last,
    output logic [NUM_CLIENTS-1:0]        cl_gnt,
    output logic [NUM_CLIENTS-1:0]        cl_ack,
    output logic                          fb_we,
    output logic [ADDR_W-1:0]             fb_addr,
    output logic [DATA_W-1:0]             fb_data,
    output logic                          busy,
    input  logic                          err_clr,
    output logic                          err_oob,
    output logic [2:0]                    err_client
);

    // One extra bit so FB_DEPTH == 2**ADDR_W does not wrap to zero.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(FB_DEPTH);
    localparam logic [7:0]      BURST_LIM = 8'(BURST_MAX);
    localparam logic [2:0]      LAST_IDX  = 3'(NUM_CLIENTS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                   state;
    logic [2:0]               owner;
    logic [2:0]               rr_ptr;
    logic [7:0]               burst_cnt;

    logic [ADDR_W-1:0]        own_addr;
    logic [DATA_W-1:0]        own_data;
    logic                     own_oob;
    logic                     wr_accept;
    logic                     wr_final;
    logic [7:0]               burst_inc;
    logic                     burst_hit;
    logic                     release_now;

    logic [2:0]               arb_base;
    logic                     win_found;
    logic [2:0]               win_idx;
    logic [NUM_CLIENTS-1:0]   win_onehot;

    // Grant is registered and one-hot, so the ack is simply the owner's request.
    assign cl_ack    = cl_gnt & cl_req;
    assign wr_accept = |cl_ack;
    assign wr_final  = |(cl_ack & cl_last);

    always_comb begin
        own_addr = '0;
        own_data = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (cl_gnt[i]) begin
                own_addr = cl_addr[i*ADDR_W +: ADDR_W];
                own_data = cl_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign own_oob   = ({1'b0, own_addr} >= DEPTH_EXT);
    assign burst_inc = (burst_cnt == 8'hFF) ? 8'hFF : burst_cnt + 8'd1;
    assign burst_hit = (RR_MODE != 0) && wr_accept && (burst_inc == BURST_LIM);

    // In GRANT a cycle without the owner's request is itself a release.
    assign release_now = !wr_accept || wr_final || burst_hit;

    // Rotating search: first pass looks at indices >= base, second pass wraps
    // to the lowest requester. Fixed mode uses base 0 so the first pass alone
    // yields the lowest requesting index.
    always_comb begin
        arb_base   = (RR_MODE != 0) ? rr_ptr : 3'd0;
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!win_found && cl_req[i] && (3'(i) >= arb_base)) begin
                win_found     = 1'b1;
                win_idx       = 3'(i);
                win_onehot[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!win_found && cl_req[i]) begin
                win_found     = 1'b1;
                win_idx       = 3'(i);
                win_onehot[i] = 1'b1;
            end
        end
    end

    // Stage p1: grant FSM, registered frame buffer port and error capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cl_gnt     <= '0;
            busy       <= 1'b0;
            owner      <= '0;
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            err_oob    <= 1'b0;
            err_client <= '0;
        end else begin
            fb_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state  <= GRANT;
                        cl_gnt <= win_onehot;
                        owner  <= win_idx;
                        busy   <= 1'b1;
                    end
                end
                GRANT: begin
                    if (wr_accept) begin
                        burst_cnt <= burst_inc;
                        // Out-of-bounds writes are consumed but never reach the RAM.
                        if (!own_oob) begin
                            fb_we   <= 1'b1;
                            fb_addr <= own_addr;
                            fb_data <= own_data;
                        end
                    end
                    if (release_now) begin
                        state     <= IDLE;
                        cl_gnt    <= '0;
                        busy      <= 1'b0;
                        burst_cnt <= '0;
                        rr_ptr    <= (owner == LAST_IDX) ? 3'd0 : owner + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A new violation beats a simultaneous clear and reports its own index.
            if (wr_accept && own_oob) begin
                err_oob <= 1'b1;
                if (!err_oob || err_clr) begin
                    err_client <= owner;
                end
            end else if (err_clr) begin
                err_oob    <= 1'b0;
                err_client <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
`timescale 1ns/1ps
module tb_fb_write_arbiter;

    localparam int AW    = 17;
    localparam int DW    = 24;
    localparam int DEPTH = 76800;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } wr_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_t;

    // Fixed-priority instance, 2 clients
    logic [1:0]      f_req, f_last, f_gnt, f_ack, f_hold;
    logic [2*AW-1:0] f_addr;
    logic [2*DW-1:0] f_data;
    logic            f_we, f_busy, f_err_clr, f_err_oob;
    logic [AW-1:0]   f_fb_addr;
    logic [DW-1:0]   f_fb_data;
    logic [2:0]      f_err_client;

    // Round-robin instance, 3 clients, burst limit 3
    logic [2:0]      r_req, r_last, r_gnt, r_ack;
    logic [3*AW-1:0] r_addr;
    logic [3*DW-1:0] r_data;
    logic            r_we, r_busy, r_err_clr, r_err_oob;
    logic [AW-1:0]   r_fb_addr;
    logic [DW-1:0]   r_fb_data;
    logic [2:0]      r_err_client;

    wr_t fq[2][$];
    wr_t rq[3][$];
    sb_t f_sb[$];
    sb_t r_sb[$];

    fb_write_arbiter #(.NUM_CLIENTS(2), .ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(DEPTH),
                       .RR_MODE(0), .BURST_MAX(64)) dut_fx (
        .clk(clk), .rst_n(rst_n), .cl_req(f_req), .cl_addr(f_addr), .cl_data(f_data),
        .cl_last(f_last), .cl_gnt(f_gnt), .cl_ack(f_ack), .fb_we(f_we), .fb_addr(f_fb_addr),
        .fb_data(f_fb_data), .busy(f_busy), .err_clr(f_err_clr), .err_oob(f_err_oob),
        .err_client(f_err_client));

    fb_write_arbiter #(.NUM_CLIENTS(3), .ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(DEPTH),
                       .RR_MODE(1), .BURST_MAX(3)) dut_rr (
        .clk(clk), .rst_n(rst_n), .cl_req(r_req), .cl_addr(r_addr), .cl_data(r_data),
        .cl_last(r_last), .cl_gnt(r_gnt), .cl_ack(r_ack), .fb_we(r_we), .fb_addr(r_fb_addr),
        .fb_data(r_fb_data), .busy(r_busy), .err_clr(r_err_clr), .err_oob(r_err_oob),
        .err_client(r_err_client));

    function automatic wr_t mk(input int a, input logic [DW-1:0] d, input logic l);
        wr_t w;
        w.addr = AW'(a);
        w.data = d;
        w.last = l;
        return w;
    endfunction

    task automatic drive_f();
        for (int i = 0; i < 2; i++) begin
            if (fq[i].size() > 0 && !f_hold[i]) begin
                f_req[i]            = 1'b1;
                f_addr[i*AW +: AW]  = fq[i][0].addr;
                f_data[i*DW +: DW]  = fq[i][0].data;
                f_last[i]           = fq[i][0].last;
            end else begin
                f_req[i]  = 1'b0;
                f_last[i] = 1'b0;
            end
        end
    endtask

    task automatic drive_r();
        for (int i = 0; i < 3; i++) begin
            if (rq[i].size() > 0) begin
                r_req[i]            = 1'b1;
                r_addr[i*AW +: AW]  = rq[i][0].addr;
                r_data[i*DW +: DW]  = rq[i][0].data;
                r_last[i]           = rq[i][0].last;
            end else begin
                r_req[i]  = 1'b0;
                r_last[i] = 1'b0;
            end
        end
    endtask

    // Called mid-cycle: an acked write is consumed at the coming edge; the
    // client presents its next write just after that edge.
    task automatic advance_f();
        logic [1:0] a;
        a = f_ack;
        for (int i = 0; i < 2; i++)
            if (a[i] && fq[i].size() > 0 && int'(fq[i][0].addr) < DEPTH)
                f_sb.push_back({fq[i][0].addr, fq[i][0].data});
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++)
            if (a[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        drive_f();
    endtask

    task automatic advance_r();
        logic [2:0] a;
        a = r_ack;
        for (int i = 0; i < 3; i++)
            if (a[i] && rq[i].size() > 0 && int'(rq[i][0].addr) < DEPTH)
                r_sb.push_back({rq[i][0].addr, rq[i][0].data});
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            if (a[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        drive_r();
    endtask

    // Write-port scoreboards
    always @(negedge clk) begin
        if (f_we === 1'b1) begin
            sb_t e;
            checks++;
            if (f_sb.size() == 0) begin
                errors++;
                $display("FAIL f_write_extra: got addr %h data %h, expected no write", f_fb_addr, f_fb_data);
            end else begin
                e = f_sb.pop_front();
                if ({f_fb_addr, f_fb_data} !== e) begin
                    errors++;
                    $display("FAIL f_write: got %h/%h, expected %h/%h", f_fb_addr, f_fb_data, e.addr, e.data);
                end
            end
        end
        if (r_we === 1'b1) begin
            sb_t e;
            checks++;
            if (r_sb.size() == 0) begin
                errors++;
                $display("FAIL r_write_extra: got addr %h data %h, expected no write", r_fb_addr, r_fb_data);
            end else begin
                e = r_sb.pop_front();
                if ({r_fb_addr, r_fb_data} !== e) begin
                    errors++;
                    $display("FAIL r_write: got %h/%h, expected %h/%h", r_fb_addr, r_fb_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic test_reset();
        f_req = '0; f_last = '0; f_addr = '0; f_data = '0; f_hold = '0; f_err_clr = 1'b0;
        r_req = '0; r_last = '0; r_addr = '0; r_data = '0; r_err_clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({f_gnt, f_ack, f_we, f_fb_addr, f_fb_data, f_busy, f_err_oob, f_err_client} !== '0) begin
            errors++;
            $display("FAIL reset_f: got gnt=%b ack=%b we=%b busy=%b err=%b/%0d, expected all 0",
                     f_gnt, f_ack, f_we, f_busy, f_err_oob, f_err_client);
        end
        checks++;
        if ({r_gnt, r_ack, r_we, r_fb_addr, r_fb_data, r_busy, r_err_oob, r_err_client} !== '0) begin
            errors++;
            $display("FAIL reset_r: got gnt=%b ack=%b we=%b busy=%b, expected all 0", r_gnt, r_ack, r_we, r_busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({f_gnt, f_busy, r_gnt, r_busy} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got f_gnt=%b r_gnt=%b, expected 0 with no requests", f_gnt, r_gnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_burst();
        logic [1:0] eg;
        logic       ew;
        for (int k = 0; k < 4; k++) fq[0].push_back(mk(k, 24'hFF0000, k == 3));
        drive_f();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            eg = (c >= 1 && c <= 4) ? 2'b01 : 2'b00;
            ew = (c >= 2 && c <= 5);
            checks++;
            if (f_gnt !== eg) begin errors++; $display("FAIL single_gnt c%0d: got %b, expected %b", c, f_gnt, eg); end
            checks++;
            if (f_ack !== eg) begin errors++; $display("FAIL single_ack c%0d: got %b, expected %b", c, f_ack, eg); end
            checks++;
            if (f_busy !== |eg) begin errors++; $display("FAIL single_busy c%0d: got %b, expected %b", c, f_busy, |eg); end
            checks++;
            if (f_we !== ew) begin errors++; $display("FAIL single_we c%0d: got %b, expected %b", c, f_we, ew); end
            if (ew) begin
                checks++;
                if (f_fb_addr !== AW'(c - 2)) begin
                    errors++; $display("FAIL single_addr c%0d: got %0d, expected %0d", c, f_fb_addr, c - 2);
                end
            end
            advance_f();
        end
        checks++;
        if (f_sb.size() != 0) begin errors++; $display("FAIL single_drain: got %0d pending, expected 0", f_sb.size()); end
    endtask

    task automatic test_fixed_priority();
        logic [1:0] eg_t [9];
        int         ea_t [9];
        eg_t = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
        ea_t = '{-1, -1, 10, 11, 12, -1, 20, 21, -1};
        for (int k = 0; k < 3; k++) fq[0].push_back(mk(10 + k, 24'h00AA00 + DW'(k), k == 2));
        for (int k = 0; k < 2; k++) fq[1].push_back(mk(20 + k, 24'h0000BB + DW'(k), k == 1));
        drive_f();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if (f_gnt !== eg_t[c]) begin errors++; $display("FAIL prio_gnt c%0d: got %b, expected %b", c, f_gnt, eg_t[c]); end
            checks++;
            if (f_ack !== eg_t[c]) begin errors++; $display("FAIL prio_ack c%0d: got %b, expected %b", c, f_ack, eg_t[c]); end
            checks++;
            if (f_we !== (ea_t[c] >= 0)) begin errors++; $display("FAIL prio_we c%0d: got %b, expected %b", c, f_we, ea_t[c] >= 0); end
            if (ea_t[c] >= 0) begin
                checks++;
                if (f_fb_addr !== AW'(ea_t[c])) begin
                    errors++; $display("FAIL prio_addr c%0d: got %0d, expected %0d", c, f_fb_addr, ea_t[c]);
                end
            end
            advance_f();
        end
        checks++;
        if (f_sb.size() != 0) begin errors++; $display("FAIL prio_drain: got %0d pending, expected 0", f_sb.size()); end
    endtask

    task automatic test_oob();
        // Client 1: out-of-bounds write, then an in-bounds one
        fq[1].push_back(mk(DEPTH, 24'h123456, 1'b0));
        fq[1].push_back(mk(5, 24'h654321, 1'b1));
        drive_f();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (f_err_oob !== 1'b0) begin errors++; $display("FAIL oob_pre c1: got %b, expected 0", f_err_oob); end
            end
            if (c == 2) begin
                checks++;
                if (f_ack !== 2'b10) begin errors++; $display("FAIL oob_ack c2: got %b, expected 10", f_ack); end
                checks++;
                if (f_we !== 1'b0) begin errors++; $display("FAIL oob_we c2: got %b, expected 0", f_we); end
                checks++;
                if ({f_err_oob, f_err_client} !== 4'b1_001) begin
                    errors++; $display("FAIL oob_err c2: got %b/%0d, expected 1/1", f_err_oob, f_err_client);
                end
            end
            if (c == 3) begin
                checks++;
                if ({f_we, f_fb_addr} !== {1'b1, AW'(5)}) begin
                    errors++; $display("FAIL oob_next c3: got we=%b addr=%0d, expected 1/5", f_we, f_fb_addr);
                end
            end
            advance_f();
        end
        // Client 0 out of bounds while the flag is already set: index kept
        fq[0].push_back(mk(100000, 24'h000001, 1'b1));
        drive_f();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if ({f_we, f_err_oob, f_err_client} !== 5'b0_1_001) begin
                    errors++; $display("FAIL oob_keep c2: got we=%b err=%b/%0d, expected 0 1/1", f_we, f_err_oob, f_err_client);
                end
            end
            advance_f();
        end
        // Plain clear
        f_err_clr = 1'b1;
        @(posedge clk); #1;
        f_err_clr = 1'b0;
        @(negedge clk);
        checks++;
        if ({f_err_oob, f_err_client} !== 4'b0_000) begin
            errors++; $display("FAIL oob_clr: got %b/%0d, expected 0/0", f_err_oob, f_err_client);
        end
        @(posedge clk); #1;
        // Client 1 sets the flag, then client 0 violates in the same cycle as a clear
        fq[1].push_back(mk(DEPTH + 1, 24'h000002, 1'b1));
        drive_f();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            advance_f();
        end
        checks++;
        if ({f_err_oob, f_err_client} !== 4'b1_001) begin
            errors++; $display("FAIL oob_reset_idx: got %b/%0d, expected 1/1", f_err_oob, f_err_client);
        end
        fq[0].push_back(mk(DEPTH + 2, 24'h000003, 1'b1));
        drive_f();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if ({f_err_oob, f_err_client} !== 4'b1_000) begin
                    errors++; $display("FAIL oob_clr_race c2: got %b/%0d, expected 1/0", f_err_oob, f_err_client);
                end
            end
            advance_f();
            f_err_clr = (c == 0);
        end
        f_err_clr = 1'b0;
        checks++;
        if (f_sb.size() != 0) begin errors++; $display("FAIL oob_drain: got %0d pending, expected 0", f_sb.size()); end
    endtask

    task automatic test_req_drop();
        logic [1:0] eg_t [9];
        logic [1:0] ek_t [9];
        int         ea_t [9];
        eg_t = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
        ek_t = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
        ea_t = '{-1, -1, 40, 41, -1, -1, 42, 43, -1};
        for (int k = 0; k < 4; k++) fq[0].push_back(mk(40 + k, 24'hC0FFEE - DW'(k), k == 3));
        drive_f();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if (f_gnt !== eg_t[c]) begin errors++; $display("FAIL drop_gnt c%0d: got %b, expected %b", c, f_gnt, eg_t[c]); end
            checks++;
            if (f_ack !== ek_t[c]) begin errors++; $display("FAIL drop_ack c%0d: got %b, expected %b", c, f_ack, ek_t[c]); end
            checks++;
            if (f_we !== (ea_t[c] >= 0)) begin errors++; $display("FAIL drop_we c%0d: got %b, expected %b", c, f_we, ea_t[c] >= 0); end
            if (ea_t[c] >= 0) begin
                checks++;
                if (f_fb_addr !== AW'(ea_t[c])) begin
                    errors++; $display("FAIL drop_addr c%0d: got %0d, expected %0d", c, f_fb_addr, ea_t[c]);
                end
            end
            advance_f();
            f_hold[0] = (c == 2);
            drive_f();
        end
        checks++;
        if (f_sb.size() != 0) begin errors++; $display("FAIL drop_drain: got %0d pending, expected 0", f_sb.size()); end
    endtask

    task automatic test_rr_rotation();
        logic [2:0] eg;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 6; k++)
                rq[i].push_back(mk(i * 100 + k, {8'(i), 16'(k)}, 1'b0));
        drive_r();
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            if (c == 0 || c >= 16 || ((c - 1) % 4) == 3) eg = 3'b000;
            else eg = 3'b001 << (((c - 1) / 4) % 3);
            checks++;
            if (r_gnt !== eg) begin errors++; $display("FAIL rr_gnt c%0d: got %b, expected %b", c, r_gnt, eg); end
            checks++;
            if (r_ack !== eg) begin errors++; $display("FAIL rr_ack c%0d: got %b, expected %b", c, r_ack, eg); end
            checks++;
            if (r_busy !== |eg) begin errors++; $display("FAIL rr_busy c%0d: got %b, expected %b", c, r_busy, |eg); end
            advance_r();
            if (c == 15) begin
                for (int i = 0; i < 3; i++) rq[i].delete();
                drive_r();
            end
        end
        checks++;
        if (r_sb.size() != 0) begin errors++; $display("FAIL rr_drain: got %0d pending, expected 0", r_sb.size()); end
    endtask

    task automatic test_reset_mid_burst();
        logic [2:0] eg_t [5];
        eg_t = '{3'b000, 3'b001, 3'b000, 3'b100, 3'b000};
        // Client 0 burst moves the pointer to 1
        rq[0].push_back(mk(7, 24'h0A0A0A, 1'b1));
        drive_r();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            advance_r();
        end
        for (int k = 0; k < 5; k++) rq[1].push_back(mk(200 + k, 24'h111111 * DW'(k + 1), k == 4));
        drive_r();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            advance_r();
        end
        @(negedge clk);
        checks++;
        if (r_gnt !== 3'b010) begin errors++; $display("FAIL rst_mid_gnt: got %b, expected 010", r_gnt); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({r_gnt, r_ack, r_we, r_fb_addr, r_fb_data, r_busy, r_err_oob, r_err_client} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async: got gnt=%b ack=%b we=%b addr=%0d busy=%b, expected all 0",
                     r_gnt, r_ack, r_we, r_fb_addr, r_busy);
        end
        rq[1].delete();
        rq[0].push_back(mk(8, 24'h0B0B0B, 1'b1));
        rq[2].push_back(mk(9, 24'h0C0C0C, 1'b1));
        drive_r();
        @(negedge clk);
        rst_n = 1'b1;
        advance_r();
        for (int c = 1; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (r_gnt !== eg_t[c]) begin errors++; $display("FAIL rst_rearb_gnt c%0d: got %b, expected %b", c, r_gnt, eg_t[c]); end
            checks++;
            if (r_ack !== eg_t[c]) begin errors++; $display("FAIL rst_rearb_ack c%0d: got %b, expected %b", c, r_ack, eg_t[c]); end
            advance_r();
        end
        @(negedge clk);
        checks++;
        if (r_sb.size() != 0) begin errors++; $display("FAIL rst_drain: got %0d pending, expected 0", r_sb.size()); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_fixed_priority();
        test_oob();
        test_req_drop();
        test_rr_rotation();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200us");
        $fatal(1);
    end

endmodule
